// File: rtl/keypad_code_buffer.sv
// Keypad scan-code buffer: readn handshake, DEPTH-entry code FIFO, optional hex accumulator (KEYBUF_HEX_ACC_EN).
// Latency: a captured code is visible at rd_data the cycle after key_ready is seen; readn drops that same cycle.
// Backpressure: none toward the debouncer; a valid code arriving while full without a pop is dropped and flags overflow.
module keypad_code_buffer #(
  parameter int DEPTH  = 8,
  parameter int DIGITS = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int W     = 4 * DIGITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_ready,
  input  logic [4:0]    key_code,
  output logic          readn,
  input  logic          pop,
  output logic [4:0]    rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  input  logic          clr_ovf,
  output logic [W-1:0]  hex_val,
  output logic [W-1:0]  hex_latched,
  output logic          enter_pulse
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  state_t state_q, state_d;

  logic          capture;
  logic          code_vld;
  logic          pop_en;
  logic          push_en;
  logic          ovf_set;
  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] head, tail;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (key_ready)  state_d = ACK;
      ACK:  if (!key_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    readn = 1'b1;
    if (state_q == ACK) readn = 1'b0;
  end

  // Only the IDLE->ACK edge samples key_code, so a held key_ready yields one capture.
  assign capture  = (state_q == IDLE) && key_ready;
  assign code_vld = key_code < 5'd20;

  assign full     = (count == CNT_MAX);
  assign rd_valid = (count != '0);
  assign rd_data  = mem[head];
  assign pop_en   = pop && rd_valid;
  assign push_en  = capture && code_vld && (!full || pop_en);
  assign ovf_set  = capture && code_vld && full && !pop_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_en) begin
        mem[tail] <= key_code;
        tail      <= tail + PTR_ONE;
      end
      if (pop_en) head <= head + PTR_ONE;
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

`ifdef KEYBUF_HEX_ACC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hex_val     <= '0;
      hex_latched <= '0;
      enter_pulse <= 1'b0;
    end else begin
      enter_pulse <= 1'b0;
      if (capture) begin
        case (key_code)
          5'd16: hex_val <= hex_val >> 4;
          5'd17: hex_val <= '0;
          5'd18: begin
            hex_latched <= hex_val;
            hex_val     <= '0;
            enter_pulse <= 1'b1;
          end
          default: begin
            // Codes 19..31 have bit 4 set and leave the accumulator alone.
            if (!key_code[4]) hex_val <= {hex_val[W-5:0], key_code[3:0]};
          end
        endcase
      end
    end
  end
`else
  assign hex_val     = '0;
  assign hex_latched = '0;
  assign enter_pulse = 1'b0;
`endif

endmodule
